// File: rtl/conv_feed_pkg.sv
// Shared defaults and FSM encoding for the convolution feed controller.
package conv_feed_pkg;
  localparam int N_TAP_DEF     = 32;
  localparam int DW_DEF        = 4;
  localparam int OW_DEF        = 13;
  localparam int RES_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FIRE_W  = 2'd1,
    WAIT_CR = 2'd2,
    FIRE_I  = 2'd3
  } feed_state_e;

  // LSB of lane k in a packed lane bus
  function automatic int lane_lsb(input int k, input int dw);
    return k * dw;
  endfunction
endpackage

// File: rtl/conv_feed_res_fifo.sv
// Result FIFO: wrap-around pointers one bit wider than the address, head exposed combinationally.
module conv_feed_res_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/conv_feed_ctrl.sv
// Packs a nibble stream into weight/IFM lane vectors, fires them into the conv core and
// queues its results under credit flow control. CONV_FEED_PERF_CNT_EN adds the res_cnt port.
module conv_feed_ctrl
  import conv_feed_pkg::*;
#(
  parameter int N_TAP     = N_TAP_DEF,
  parameter int DW        = DW_DEF,
  parameter int OW        = OW_DEF,
  parameter int RES_DEPTH = RES_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  input  logic                s_kind,
  output logic                weight_valid,
  output logic                in_valid,
  output logic [N_TAP*DW-1:0] w_bus,
  output logic [N_TAP*DW-1:0] ifm_bus,
  input  logic                c_out_valid,
  input  logic [OW-1:0]       c_ofm,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [OW-1:0]       r_data,
  output logic                w_loaded,
  output logic                err
`ifdef CONV_FEED_PERF_CNT_EN
  ,
  output logic [15:0]         res_cnt
`endif
);
  localparam int LW = $clog2(N_TAP);
  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam int VW = N_TAP * DW;

  feed_state_e   state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic          kind_q, kind_d;
  logic [VW-1:0] stage_q, stage_d, w_bus_q, w_bus_d, ifm_bus_q, ifm_bus_d;
  logic          weight_valid_q, weight_valid_d, in_valid_q, in_valid_d;
  logic          s_ready_q, s_ready_d, w_loaded_q, w_loaded_d, err_q, err_d;
  logic [CW-1:0] inflight_q, inflight_d;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic          fifo_full, fifo_empty, accept, fire_i, ret_ok, push, pop, credit_ok, is_weight;

  assign accept    = s_valid & s_ready_q;
  assign used      = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign credit_ok = used < (CW+1)'(RES_DEPTH);
  assign ret_ok    = c_out_valid & (inflight_q != '0);
  assign push      = ret_ok & ~fifo_full;
  assign pop       = r_ready & ~fifo_empty;
  assign is_weight = (lane_q == '0) ? s_kind : kind_q;

  always_comb begin
    state_d        = state_q;
    lane_d         = lane_q;
    kind_d         = kind_q;
    stage_d        = stage_q;
    w_bus_d        = w_bus_q;
    ifm_bus_d      = ifm_bus_q;
    weight_valid_d = 1'b0;
    in_valid_d     = 1'b0;
    s_ready_d      = s_ready_q;
    w_loaded_d     = w_loaded_q;
    fire_i         = 1'b0;
    case (state_q)
      COLLECT: begin
        s_ready_d = 1'b1;
        if (accept) begin
          stage_d[lane_lsb(int'(lane_q), DW) +: DW] = s_data;
          if (lane_q == '0) kind_d = s_kind;
          if (lane_q == LW'(N_TAP-1)) begin
            lane_d    = '0;
            s_ready_d = 1'b0;
            state_d   = is_weight ? FIRE_W : WAIT_CR;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      FIRE_W: begin
        w_bus_d        = stage_q;
        weight_valid_d = 1'b1;
        w_loaded_d     = 1'b1;
        s_ready_d      = 1'b1;
        state_d        = COLLECT;
      end
      WAIT_CR: begin
        if (credit_ok) state_d = FIRE_I;
      end
      FIRE_I: begin
        ifm_bus_d  = stage_q;
        in_valid_d = 1'b1;
        fire_i     = 1'b1;
        s_ready_d  = 1'b1;
        state_d    = COLLECT;
      end
      default: state_d = COLLECT;
    endcase

    // A fire and a return in the same cycle cancel out
    inflight_d = inflight_q;
    case ({fire_i, ret_ok})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    err_d = err_q | (c_out_valid & ((inflight_q == '0) | fifo_full));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= COLLECT;
      lane_q         <= '0;
      kind_q         <= 1'b0;
      stage_q        <= '0;
      w_bus_q        <= '0;
      ifm_bus_q      <= '0;
      weight_valid_q <= 1'b0;
      in_valid_q     <= 1'b0;
      s_ready_q      <= 1'b0;
      w_loaded_q     <= 1'b0;
      err_q          <= 1'b0;
      inflight_q     <= '0;
    end else begin
      state_q        <= state_d;
      lane_q         <= lane_d;
      kind_q         <= kind_d;
      stage_q        <= stage_d;
      w_bus_q        <= w_bus_d;
      ifm_bus_q      <= ifm_bus_d;
      weight_valid_q <= weight_valid_d;
      in_valid_q     <= in_valid_d;
      s_ready_q      <= s_ready_d;
      w_loaded_q     <= w_loaded_d;
      err_q          <= err_d;
      inflight_q     <= inflight_d;
    end
  end

  conv_feed_res_fifo #(.W(OW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (c_ofm),
    .pop       (pop),
    .head      (r_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign s_ready      = s_ready_q;
  assign weight_valid = weight_valid_q;
  assign in_valid     = in_valid_q;
  assign w_bus        = w_bus_q;
  assign ifm_bus      = ifm_bus_q;
  assign r_valid      = ~fifo_empty;
  assign w_loaded     = w_loaded_q;
  assign err          = err_q;

`ifdef CONV_FEED_PERF_CNT_EN
  logic [15:0] res_cnt_q, res_cnt_d;
  assign res_cnt_d = res_cnt_q + 16'(pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_cnt_q <= '0;
    else        res_cnt_q <= res_cnt_d;
  end
  assign res_cnt = res_cnt_q;
`endif
endmodule

// File: tb/tb_conv_feed_ctrl.sv
// Bench for conv_feed_ctrl: behavioural core with a 2-cycle result pipe, result scoreboard.
module tb_conv_feed_ctrl;
  localparam int N   = 32;
  localparam int DW  = 4;
  localparam int OW  = 13;
  localparam int VW  = N * DW;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0, s_kind = 1'b0, r_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, weight_valid, in_valid, r_valid, w_loaded, err, c_out_valid;
  logic [VW-1:0] w_bus, ifm_bus;
  logic [OW-1:0] r_data, c_ofm;
`ifdef CONV_FEED_PERF_CNT_EN
  logic [15:0]   res_cnt;
`endif

  always #5 clk = ~clk;

  conv_feed_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_kind(s_kind), .weight_valid(weight_valid), .in_valid(in_valid), .w_bus(w_bus),
    .ifm_bus(ifm_bus), .c_out_valid(c_out_valid), .c_ofm(c_ofm), .r_valid(r_valid),
    .r_ready(r_ready), .r_data(r_data), .w_loaded(w_loaded), .err(err)
`ifdef CONV_FEED_PERF_CNT_EN
    , .res_cnt(res_cnt)
`endif
  );

  function automatic logic [OW-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(a[DW*k +: DW]) * int'(b[DW*k +: DW]);
    return OW'(s);
  endfunction

  // Behavioural convolution core: latches weights, returns the dot product LAT cycles later
  logic [VW-1:0]  core_w = '0;
  logic [LAT-1:0] vld_pipe = '0;
  logic [OW-1:0]  d0 = '0, d1 = '0;
  logic           inj_vld = 1'b0;
  logic [OW-1:0]  inj_data = '0;
  always @(posedge clk) begin
    if (weight_valid) core_w <= w_bus;
    vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
    d0 <= dot(core_w, ifm_bus);
    d1 <= d0;
  end
  assign c_out_valid = vld_pipe[LAT-1] | inj_vld;
  assign c_ofm       = inj_vld ? inj_data : d1;

  int tests = 0, fails = 0;
  int wv_cnt = 0, iv_cnt = 0;
  logic iv_prev = 1'b0, srdy_smp = 1'b0;
  logic [OW-1:0] exp_q[$];
  logic [VW-1:0] model_w = '0;

  // One clock: sample on the falling edge, pop the scoreboard, return just after the rising edge
  task automatic step();
    logic [OW-1:0] e;
    @(negedge clk);
    srdy_smp = s_ready;
    if (weight_valid) wv_cnt++;
    if (in_valid) begin
      iv_cnt++;
      tests++;
      if (iv_prev) begin
        fails++;
        $display("FAIL in_valid_width: high on consecutive cycles, required 1-cycle pulse");
      end
    end
    iv_prev = in_valid;
    if (rst_n && r_valid && r_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: unexpected result %0d, required none", r_data);
      end else begin
        e = exp_q.pop_front();
        if (r_data !== e) begin
          fails++;
          $display("FAIL scoreboard: r_data=%0d required %0d", r_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [DW-1:0] d, input logic k, output bit ok);
    s_valid = 1'b1; s_data = d; s_kind = k; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = srdy_smp;
    end
  endtask

  task automatic send_vec(input logic k, input logic [VW-1:0] v);
    bit ok;
    for (int i = 0; i < N; i++) begin
      send_nib(v[DW*i +: DW], k, ok);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL send_timeout: lane %0d not accepted, required acceptance within 200 cycles", i);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    if (k) model_w = v;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[DW*i +: DW] = DW'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    tests++;
    if ({s_ready, weight_valid, in_valid, r_valid, w_loaded, err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: {s_ready,wv,iv,r_valid,w_loaded,err}=%b required 000000",
               {s_ready, weight_valid, in_valid, r_valid, w_loaded, err});
    end
    tests++;
    if ((w_bus | ifm_bus) !== '0) begin
      fails++;
      $display("FAIL reset_bus: w_bus|ifm_bus=%h required 0", w_bus | ifm_bus);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: s_ready=%b required 1", s_ready);
    end
  endtask

  task automatic test_basic();
    int wv0, iv0;
    logic [VW-1:0] ramp;
    for (int i = 0; i < N; i++) ramp[DW*i +: DW] = DW'(i % 16);
    r_ready = 1'b1;
    wv0 = wv_cnt; iv0 = iv_cnt;
    send_vec(1'b1, {N{4'd1}});
    exp_q.push_back(13'd480);
    send_vec(1'b0, {N{4'hF}});
    repeat (8) step();
    tests++;
    if (wv_cnt - wv0 !== 1 || iv_cnt - iv0 !== 1) begin
      fails++;
      $display("FAIL basic_pulses: weight_valid=%0d in_valid=%0d required 1 and 1", wv_cnt - wv0, iv_cnt - iv0);
    end
    tests++;
    if (w_loaded !== 1'b1 || w_bus !== {N{4'd1}}) begin
      fails++;
      $display("FAIL basic_wbus: w_loaded=%b w_bus=%h required 1 and all-1 lanes", w_loaded, w_bus);
    end
    tests++;
    if (ifm_bus !== {N{4'hF}}) begin
      fails++;
      $display("FAIL basic_ifmbus: ifm_bus=%h required all-F lanes", ifm_bus);
    end
    send_vec(1'b1, {N{4'hF}});
    exp_q.push_back(13'd7200);
    send_vec(1'b0, {N{4'hF}});
    send_vec(1'b1, ramp);
    exp_q.push_back(13'd240);
    send_vec(1'b0, {N{4'd1}});
    repeat (8) step();
    tests++;
    if (exp_q.size() != 0 || iv_cnt - iv0 !== 3) begin
      fails++;
      $display("FAIL basic_drain: pending=%0d in_valid=%0d required 0 and 3", exp_q.size(), iv_cnt - iv0);
    end
  endtask

  task automatic test_credit();
    int iv0;
    bit stuck;
    logic [VW-1:0] v;
    r_ready = 1'b0;
    iv0 = iv_cnt;
    for (int i = 0; i < 5; i++) begin
      v = rand_vec();
      exp_q.push_back(dot(model_w, v));
      send_vec(1'b0, v);
    end
    stuck = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (srdy_smp) stuck = 1'b0;
    end
    tests++;
    if (!stuck) begin
      fails++;
      $display("FAIL credit_sready: s_ready=1 seen while waiting for credit, required 0");
    end
    tests++;
    if (iv_cnt - iv0 !== 4 || r_valid !== 1'b1) begin
      fails++;
      $display("FAIL credit_block: in_valid=%0d r_valid=%b required 4 and 1", iv_cnt - iv0, r_valid);
    end
    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    repeat (8) step();
    tests++;
    if (iv_cnt - iv0 !== 5) begin
      fails++;
      $display("FAIL credit_release: in_valid=%0d required 5", iv_cnt - iv0);
    end
    r_ready = 1'b1;
    repeat (10) step();
    tests++;
    if (exp_q.size() != 0 || r_valid !== 1'b0) begin
      fails++;
      $display("FAIL credit_drain: pending=%0d r_valid=%b required 0 and 0", exp_q.size(), r_valid);
    end
  endtask

  task automatic test_reset_mid();
    int iv0;
    bit ok;
    logic [VW-1:0] v;
    r_ready = 1'b1;
    iv0 = iv_cnt;
    v = rand_vec();
    for (int i = 0; i <= 10; i++) send_nib(v[DW*i +: DW], 1'b0, ok);
    s_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    tests++;
    if (iv_cnt !== iv0) begin
      fails++;
      $display("FAIL midreset_nofire: in_valid=%0d required 0", iv_cnt - iv0);
    end
    v = rand_vec();
    exp_q.push_back(dot(model_w, v));
    send_vec(1'b0, v);
    repeat (8) step();
    tests++;
    if (iv_cnt - iv0 !== 1 || exp_q.size() != 0 || ifm_bus !== v) begin
      fails++;
      $display("FAIL midreset_clean: in_valid=%0d pending=%0d ifm_bus=%h required 1, 0, %h",
               iv_cnt - iv0, exp_q.size(), ifm_bus, v);
    end
    tests++;
    if (err !== 1'b0 || w_loaded !== 1'b0) begin
      fails++;
      $display("FAIL midreset_flags: err=%b w_loaded=%b required 0 and 0", err, w_loaded);
    end
  endtask

  task automatic test_err();
    inj_vld = 1'b1;
    inj_data = 13'd123;
    step();
    inj_vld = 1'b0;
    repeat (2) step();
    tests++;
    if (err !== 1'b1 || r_valid !== 1'b0) begin
      fails++;
      $display("FAIL spurious_return: err=%b r_valid=%b required 1 and 0", err, r_valid);
    end
  endtask

  task automatic test_perf();
    logic [VW-1:0] v;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_reset: err=%b required 0", err);
    end
    r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = rand_vec();
      exp_q.push_back(dot(model_w, v));
      send_vec(1'b0, v);
    end
    repeat (6) step();
    r_ready = 1'b1;
    repeat (8) step();
    tests++;
    if (exp_q.size() != 0 || r_valid !== 1'b0) begin
      fails++;
      $display("FAIL perf_drain: pending=%0d r_valid=%b required 0 and 0", exp_q.size(), r_valid);
    end
`ifdef CONV_FEED_PERF_CNT_EN
    tests++;
    if (res_cnt !== 16'd3) begin
      fails++;
      $display("FAIL res_cnt: res_cnt=%0d required 3", res_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_reset_mid();
    test_err();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
